bit_align_fsm: RTL

BIT_ALIGN_FSM -- requirements
Module: bit_align_fsm

---
 rtl/bit_align_fsm.sv | 89 ++++++++
 1 files changed

// File: rtl/bit_align_fsm.sv
// bit_align_fsm: steps a delay-line selector upward until the training pattern
// is seen MATCH_CNT times in a row, then tracks lock and re-searches on loss.
module bit_align_fsm #(
  parameter int WIDTH     = 4,
  parameter int LENGTH    = 63,
  parameter int SEL_W     = $clog2((LENGTH+1)*WIDTH),
  parameter int MATCH_CNT = 8,
  parameter int MISS_CNT  = 4,
  parameter int SETTLE    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [WIDTH-1:0] data_in,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             locked,
  output logic             fail,
  output logic             lost
);
  localparam int SEL_MAX = LENGTH*WIDTH;
  localparam int MW = $clog2(MATCH_CNT+1);
  localparam int XW = $clog2(MISS_CNT+1);
  localparam int SW = SETTLE > 0 ? $clog2(SETTLE+1) : 1;
  typedef enum logic [2:0] {IDLE, SETL, CHECK, LOCK, FAILED} state_t;
  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [MW-1:0]    r_match;
  logic [XW-1:0]    r_miss;
  logic [SW-1:0]    r_set;
  logic             r_lost;
  logic             w_eq, w_set_done, w_match_done, w_miss_done, w_sel_top;
  assign w_eq         = data_in == pattern;
  assign w_set_done   = int'(r_set) + 1 >= SETTLE;
  assign w_match_done = int'(r_match) + 1 >= MATCH_CNT;
  assign w_miss_done  = int'(r_miss) + 1 >= MISS_CNT;
  assign w_sel_top    = r_sel >= SEL_W'(SEL_MAX);
  assign sel    = r_sel;
  assign busy   = r_state == SETL || r_state == CHECK;
  assign locked = r_state == LOCK;
  assign fail   = r_state == FAILED;
  assign lost   = r_lost;
  always_ff @(posedge clk) begin
    if (rst || start) begin
      r_state <= rst ? IDLE : SETL;
      r_sel   <= '0;
      r_match <= '0;
      r_miss  <= '0;
      r_set   <= '0;
      r_lost  <= 1'b0;
    end else begin
      r_lost <= 1'b0;
      if (ena) begin
        case (r_state)
          SETL:
            if (w_set_done) begin
              r_state <= CHECK;
              r_match <= '0;
              r_set   <= '0;
            end else r_set <= r_set + 1'b1;
          CHECK:
            if (w_eq) begin
              if (w_match_done) begin
                r_state <= LOCK;
                r_miss  <= '0;
              end else r_match <= r_match + 1'b1;
            end else if (w_sel_top) r_state <= FAILED;
            else begin
              r_sel   <= r_sel + 1'b1;
              r_state <= SETL;
              r_set   <= '0;
            end
          LOCK:
            if (w_eq) r_miss <= '0;
            else if (w_miss_done) begin
              // re-verify the current tap before searching further up
              r_lost  <= 1'b1;
              r_state <= SETL;
              r_set   <= '0;
              r_miss  <= '0;
            end else r_miss <= r_miss + 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule
